fse_fir_slicer: RTL



---
 rtl/fse_fir_slicer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fse_fir_slicer.sv
// fse_fir_slicer: pipelined fractionally-spaced FIR equalizer with hard +/-1 slicer and saturation counter
module fse_fir_slicer #(
    parameter int NBx  = 8,
    parameter int NBFx = 5,
    parameter int Nw   = 9,
    parameter int NBw  = 7,
    parameter int NBFw = 5,
    parameter int NBy  = 8,
    parameter int NBFy = 5,
    parameter int NBsc = 16
) (
    input  logic                   clkA,
    input  logic                   reset,
    input  logic                   i_enable,
    input  logic signed [NBx-1:0]  x,
    input  logic [Nw*NBw-1:0]      coeff,
    input  logic                   i_coeff_freeze,
    output logic signed [NBy-1:0]  y,
    output logic                   d,
    output logic                   o_valid,
    output logic signed [NBx-1:0]  o_x_align,
    output logic [NBsc-1:0]        o_sat_count
);
    localparam int NBp = NBx + NBw;
    localparam int NBs = NBp + $clog2(Nw);
    localparam int SH  = NBFx + NBFw - NBFy;
    localparam int NBt = NBs - SH;

    logic signed [NBx-1:0] r_tap [Nw];
    logic signed [NBw-1:0] r_w   [Nw];
    logic signed [NBp-1:0] r_p   [Nw];
    logic signed [NBx-1:0] r_xa0, r_xa1;
    logic                  r_v0, r_v1;
    logic signed [NBs-1:0] w_sum;
    logic signed [NBt-1:0] w_trunc;
    logic [NBt-NBy:0]      w_hi;
    logic                  w_sat;
    logic signed [NBy-1:0] w_y;

    // coefficient register: reload every edge unless frozen
    always_ff @(posedge clkA) begin
        if (!reset) begin
            for (int k = 0; k < Nw; k++) r_w[k] <= '0;
        end else if (!i_coeff_freeze) begin
            for (int k = 0; k < Nw; k++) r_w[k] <= coeff[NBw*k +: NBw];
        end
    end

    // stage 0: tap line and first alignment slot move only on a sample strobe
    always_ff @(posedge clkA) begin
        if (!reset) begin
            for (int k = 0; k < Nw; k++) r_tap[k] <= '0;
            r_xa0 <= '0;
            r_v0  <= 1'b0;
        end else begin
            r_v0 <= i_enable;
            if (i_enable) begin
                r_tap[0] <= x;
                for (int k = 1; k < Nw; k++) r_tap[k] <= r_tap[k-1];
                r_xa0 <= x;
            end
        end
    end

    // stage 1: per-tap products, free-running; validity rides on r_v1
    always_ff @(posedge clkA) begin
        if (!reset) begin
            for (int k = 0; k < Nw; k++) r_p[k] <= '0;
            r_xa1 <= '0;
            r_v1  <= 1'b0;
        end else begin
            for (int k = 0; k < Nw; k++) r_p[k] <= NBp'(r_tap[k]) * NBp'(r_w[k]);
            r_xa1 <= r_xa0;
            r_v1  <= r_v0;
        end
    end

    // adder tree, floor truncation and saturation to the output format
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < Nw; k++) w_sum = w_sum + {{(NBs-NBp){r_p[k][NBp-1]}}, r_p[k]};
        w_trunc = NBt'(w_sum >>> SH);
        w_hi    = w_trunc[NBt-1:NBy-1];
        w_sat   = !((&w_hi) || !(|w_hi));
        w_y     = !w_sat ? w_trunc[NBy-1:0] :
                  w_trunc[NBt-1] ? {1'b1, {(NBy-1){1'b0}}} : {1'b0, {(NBy-1){1'b1}}};
    end

    // stage 2: outputs update only on valid samples and hold otherwise
    always_ff @(posedge clkA) begin
        if (!reset) begin
            y         <= '0;
            d         <= 1'b0;
            o_x_align <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= r_v1;
            if (r_v1) begin
                y         <= w_y;
                d         <= ~w_y[NBy-1];
                o_x_align <= r_xa1;
            end
        end
    end

    // saturation event counter, sticky at all-ones
    always_ff @(posedge clkA) begin
        if (!reset) o_sat_count <= '0;
        else if (r_v1 && w_sat && !(&o_sat_count)) o_sat_count <= o_sat_count + 1'b1;
    end
endmodule
